// File: rtl/sprite_index_writer.sv
// sprite_index_writer: turns a stream of 12-bit RGB pixels into 4-bit palette
// indices and writes them one per address into the indexed sprite/frame RAM.
// Colours outside the palette are written as DEFAULT_IDX and counted.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last frame's results
// RUN   | accepting pixels (in_ready=1), one write per accepted pixel
// FLUSH | last pixel's write is on the bus, no more pixels accepted
// DONE  | one-cycle done pulse, then back to IDLE
module sprite_index_writer #(
    parameter int ADDR_W      = 16,
    parameter int DEPTH       = 61952,
    parameter int IDX_W       = 4,
    parameter int DEFAULT_IDX = 0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [11:0]       in_color,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [IDX_W-1:0]  wr_data,
    output logic              busy,
    output logic              done,
    output logic [15:0]       miss_count,
    output logic              miss_err
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0]  DEF_IDX   = IDX_W'(DEFAULT_IDX);

    state_t            state;
    logic [ADDR_W-1:0] pix_cnt;
    logic              accept;
    logic              hit;
    logic [IDX_W-1:0]  enc_idx;

    // in_ready is only ever high in RUN, so this is the RUN-state handshake
    assign accept = in_valid & in_ready;

    // Palette lookup on the full 12 bits; earlier entries take priority
    always_comb begin
        enc_idx = DEF_IDX;
        hit     = 1'b1;
        if (in_color == 12'h808)      enc_idx = IDX_W'(0);
        else if (in_color == 12'h000) enc_idx = IDX_W'(1);
        else if (in_color == 12'hFCC) enc_idx = IDX_W'(2);
        else if (in_color == 12'h940) enc_idx = IDX_W'(3);
        else if (in_color == 12'h0AE) enc_idx = IDX_W'(4);
        else                          hit     = 1'b0;
    end

    // Frame sequencer with registered handshake, write port and miss statistics
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            pix_cnt    <= '0;
            in_ready   <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            miss_count <= '0;
            miss_err   <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        pix_cnt    <= '0;
                        miss_count <= '0;
                        miss_err   <= 1'b0;
                        in_ready   <= 1'b1;
                        busy       <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        wr_en   <= 1'b1;
                        wr_addr <= pix_cnt;
                        wr_data <= enc_idx;
                        if (!hit) begin
                            miss_err <= 1'b1;
                            if (miss_count != 16'hFFFF) begin
                                miss_count <= miss_count + 16'd1;
                            end
                        end
                        // stop accepting once the last address is taken; no wrap
                        if (pix_cnt == LAST_ADDR) begin
                            in_ready <= 1'b0;
                            state    <= FLUSH;
                        end else begin
                            pix_cnt <= pix_cnt + ADDR_W'(1);
                        end
                    end
                end
                FLUSH: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_index_writer.sv
// Testbench for sprite_index_writer: a DEPTH=8 instance driven cycle by cycle
// against a frame-level reference model, plus a DEPTH=70000 instance streaming
// an all-miss frame in parallel to exercise miss_count saturation.
`timescale 1ns/1ps
module tb_sprite_index_writer;

    localparam int DEPTH_S = 8;
    localparam int DEPTH_B = 70000;
    localparam logic [11:0] PAL [5] = '{12'h808, 12'h000, 12'hFCC, 12'h940, 12'h0AE};

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // small instance
    logic        Reset = 1'b1, start = 1'b0, in_valid = 1'b0;
    logic [11:0] in_color = '0;
    logic        in_ready, wr_en, busy, done, miss_err;
    logic [15:0] wr_addr;
    logic [3:0]  wr_data;
    logic [15:0] miss_count;

    // big instance
    logic        reset_b = 1'b1, start_b = 1'b0, in_valid_b = 1'b1;
    logic [11:0] in_color_b = 12'h555;
    logic        in_ready_b, wr_en_b, busy_b, done_b, miss_err_b;
    logic [16:0] wr_addr_b;
    logic [3:0]  wr_data_b;
    logic [15:0] miss_count_b;

    sprite_index_writer #(.ADDR_W(16), .DEPTH(DEPTH_S), .IDX_W(4), .DEFAULT_IDX(0)) dut (
        .Clk(clk), .Reset(Reset), .start(start), .in_color(in_color), .in_valid(in_valid),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .miss_count(miss_count), .miss_err(miss_err));

    sprite_index_writer #(.ADDR_W(17), .DEPTH(DEPTH_B), .IDX_W(4), .DEFAULT_IDX(0)) dut_big (
        .Clk(clk), .Reset(reset_b), .start(start_b), .in_color(in_color_b), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .busy(busy_b), .done(done_b), .miss_count(miss_count_b), .miss_err(miss_err_b));

    int n_pass = 0;
    int n_total = 0;

    // reference model state (frame level)
    bit          m_active = 0;   // frame open and still accepting pixels
    int          m_tail = 0;     // 1: last write on bus, 2: done cycle
    int          m_n = 0;        // pixels accepted in this frame
    bit          m_busy = 0, m_wr_en = 0, m_done = 0, m_err = 0;
    int          m_addr = 0, m_data = 0, m_miss = 0;

    logic [11:0] pix_q [$];

    // big-instance observation
    int          nb_wr = 0, bad_addr_b = 0, nb_done = 0;
    logic [16:0] last_addr_b = '0;
    logic [15:0] miss_done_b = '0;

    always @(posedge clk) begin
        if (wr_en_b) begin
            if (int'(wr_addr_b) != nb_wr) bad_addr_b++;
            if (wr_data_b !== 4'd0) bad_addr_b++;
            last_addr_b = wr_addr_b;
            nb_wr++;
        end
        if (done_b) begin
            nb_done++;
            miss_done_b = miss_count_b;
        end
    end

    function automatic int ref_idx(input logic [11:0] c);
        for (int i = 0; i < 5; i++) if (PAL[i] == c) return i;
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // one clock: apply inputs, advance the model, compare every output
    task automatic tick(input logic v, input logic [11:0] c, input logic s, input logic r);
        bit idle_pre;
        int ix;
        in_valid = v; in_color = c; start = s; Reset = r;
        @(posedge clk);
        if (r) begin
            m_active = 0; m_tail = 0; m_n = 0; m_busy = 0; m_wr_en = 0; m_done = 0;
            m_err = 0; m_addr = 0; m_data = 0; m_miss = 0;
        end else begin
            idle_pre = !m_active && m_tail == 0;
            m_wr_en = 0;
            m_done = 0;
            if (m_tail == 1) begin
                m_tail = 2; m_done = 1; m_busy = 0;
            end else if (m_tail == 2) begin
                m_tail = 0;
            end
            if (m_active && v) begin
                ix = ref_idx(c);
                m_wr_en = 1;
                m_addr = m_n;
                m_data = (ix < 0) ? 0 : ix;
                if (ix < 0) begin
                    m_err = 1;
                    if (m_miss < 65535) m_miss++;
                end
                m_n++;
                if (m_n == DEPTH_S) begin
                    m_active = 0; m_tail = 1;
                end
            end else if (idle_pre && s) begin
                m_active = 1; m_busy = 1; m_n = 0; m_miss = 0; m_err = 0;
            end
        end
        #1;
        check("in_ready", 32'(in_ready), 32'(m_active));
        check("wr_en", 32'(wr_en), 32'(m_wr_en));
        check("wr_addr", 32'(wr_addr), 32'(m_addr));
        check("wr_data", 32'(wr_data), 32'(m_data));
        check("busy", 32'(busy), 32'(m_busy));
        check("done", 32'(done), 32'(m_done));
        check("miss_count", 32'(miss_count), 32'(m_miss));
        check("miss_err", 32'(miss_err), 32'(m_err));
    endtask

    // start a frame and feed pix_q; gap_mode 0 back-to-back, 1 pattern 1,0,0, 2 random
    task automatic run_frame(input int gap_mode, input bit start_spam);
        int   guard;
        bit   v;
        bit   acc;
        logic [11:0] c;
        guard = 0;
        tick(1'b0, 12'h0, 1'b1, 1'b0);
        while ((m_active || m_tail != 0) && guard < 200) begin
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = (guard % 3 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            c = (pix_q.size() > 0) ? pix_q[0] : 12'h808;
            acc = m_active && v;
            tick(v, c, start_spam, 1'b0);
            if (acc && pix_q.size() > 0) void'(pix_q.pop_front());
            guard++;
        end
        check("frame_timeout", 32'(guard < 200), 32'd1);
        repeat (2) tick(1'b0, 12'h0, 1'b0, 1'b0);
    endtask

    task automatic fill_random();
        pix_q.delete();
        for (int i = 0; i < DEPTH_S; i++) begin
            if ($urandom_range(0, 3) == 0) pix_q.push_back(12'($urandom));
            else pix_q.push_back(PAL[$urandom_range(0, 4)]);
        end
    endtask

    initial begin
        int g;
        // reset both instances, then launch the long all-miss frame
        tick(1'b0, 12'h0, 1'b0, 1'b1);
        tick(1'b0, 12'h0, 1'b0, 1'b1);
        reset_b = 1'b0;
        start_b = 1'b1;
        tick(1'b0, 12'h0, 1'b0, 1'b0);
        start_b = 1'b0;

        // back-to-back palette pixels
        pix_q = '{12'h808, 12'h000, 12'hFCC, 12'h940, 12'h0AE, 12'h808, 12'h000, 12'hFCC};
        run_frame(0, 1'b0);
        check("b2b_miss_count", 32'(miss_count), 32'd0);

        // gapped valid 1,0,0,1,...
        pix_q = '{12'h0AE, 12'h940, 12'hFCC, 12'h000, 12'h808, 12'h0AE, 12'h940, 12'hFCC};
        run_frame(1, 1'b0);

        // three misses among palette colours
        pix_q = '{12'h808, 12'h123, 12'h000, 12'hFFF, 12'hFCC, 12'h123, 12'h940, 12'h0AE};
        run_frame(0, 1'b0);
        check("miss3_count", 32'(miss_count), 32'd3);
        check("miss3_err", 32'(miss_err), 32'd1);
        tick(1'b0, 12'h0, 1'b1, 1'b0);
        check("miss_clear_count", 32'(miss_count), 32'd0);
        check("miss_clear_err", 32'(miss_err), 32'd0);
        pix_q = '{12'h808, 12'h808, 12'h808, 12'h808, 12'h808, 12'h808, 12'h808, 12'h808};
        while (m_active) tick(1'b1, 12'h808, 1'b0, 1'b0);
        repeat (4) tick(1'b0, 12'h0, 1'b0, 1'b0);

        // start held through RUN, FLUSH and DONE must be ignored
        pix_q = '{12'h000, 12'h000, 12'h940, 12'h940, 12'h0AE, 12'h808, 12'hFCC, 12'h000};
        run_frame(2, 1'b1);
        pix_q = '{12'h940, 12'h808, 12'h000, 12'hFCC, 12'h0AE, 12'h940, 12'h808, 12'h000};
        run_frame(0, 1'b0);

        // reset after four accepted pixels
        tick(1'b0, 12'h0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b1, PAL[i], 1'b0, 1'b0);
        tick(1'b1, 12'h0AE, 1'b0, 1'b1);
        check("rst_mid_wr_en", 32'(wr_en), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        repeat (4) tick(1'b0, 12'h0, 1'b0, 1'b0);
        pix_q = '{12'h0AE, 12'h0AE, 12'h123, 12'h000, 12'hFCC, 12'h940, 12'h808, 12'h000};
        run_frame(0, 1'b0);

        // randomized frames
        for (int f = 0; f < 4; f++) begin
            fill_random();
            run_frame(2, 1'($urandom_range(0, 1)));
        end

        // saturation frame on the large instance
        g = 0;
        while (nb_done == 0 && g < 80000) begin
            @(posedge clk);
            g++;
        end
        #1;
        check("big_done_seen", 32'(nb_done), 32'd1);
        check("big_writes", 32'(nb_wr), 32'(DEPTH_B));
        check("big_last_addr", 32'(last_addr_b), 32'(DEPTH_B - 1));
        check("big_addr_data_seq", 32'(bad_addr_b), 32'd0);
        check("big_miss_sat", 32'(miss_done_b), 32'((DEPTH_B > 65535) ? 65535 : DEPTH_B));
        check("big_miss_err", 32'(miss_err_b), 32'd1);
        check("big_in_ready_idle", 32'(in_ready_b), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sprite_index_writer.md
Name: sprite_index_writer

Overview:
- Inverse of the indexed sprite ROM path: accepts a stream of 12-bit RGB pixels and encodes each into a 4-bit palette index.
- Writes the index sequentially into an indexed sprite/frame memory (one 4-bit word per address).
- Sits between a pixel source (UART loader, test pattern, capture logic) and the sprite RAM write port that the VGA read path consumes.
- Colours not in the palette are counted and written as a default index.

Parameters:
- ADDR_W, 16, width of the write address.
- DEPTH, 61952, number of pixels per frame; the last address written is DEPTH-1.
- IDX_W, 4, width of a palette index.
- DEFAULT_IDX, 0, index written when the input colour matches no palette entry.

Ports:
- Clk  input  1  system clock; all logic is on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- start  input  1  begins a frame load; sampled only in IDLE.
- in_color  input  12  RGB 4:4:4 pixel, {R,G,B}.
- in_valid  input  1  in_color is valid this cycle.
- in_ready  output  1  the block accepts a pixel this cycle.
- wr_en  output  1  memory write strobe.
- wr_addr  output  ADDR_W  memory write address.
- wr_data  output  IDX_W  palette index to write.
- busy  output  1  high in RUN and FLUSH.
- done  output  1  one-cycle pulse at the end of a frame.
- miss_count  output  16  number of unmatched pixels in the current or last frame.
- miss_err  output  1  sticky flag, high if any miss occurred in the current or last frame.

Behaviour:
- Fixed palette, compared on the full 12 bits:
  - idx0 = 12'h808
  - idx1 = 12'h000
  - idx2 = 12'hFCC
  - idx3 = 12'h940
  - idx4 = 12'h0AE
- Lowest matching index wins. No match gives DEFAULT_IDX, miss_count+1 (saturating at 16'hFFFF) and miss_err set to 1.
- Reset values: state IDLE, pixel counter 0, and every output 0 (in_ready, wr_en, wr_addr, wr_data, busy, done, miss_count, miss_err).
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE: start=1 clears the counter, miss_count and miss_err, and moves to RUN next cycle. Otherwise stay in IDLE.
  - RUN: in_ready=1. A pixel is accepted when in_valid & in_ready. If the accepted pixel has counter==DEPTH-1, go to FLUSH; otherwise increment the counter.
  - FLUSH: in_ready=0. Finishes the pending write, then goes to DONE.
  - DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- Handshake:
  - in_ready is a registered function of state only; it does not depend on in_valid combinationally.
  - In RUN, in_valid=0 stalls the block with no write. Gaps of any length are allowed.
- Write pipeline:
  - A pixel accepted in cycle N produces wr_en=1 in cycle N+1.
  - In that cycle wr_addr equals the counter value at acceptance and wr_data is the encoded index.
  - miss_count and miss_err update in the same cycle N+1.
  - Throughput is one pixel per cycle.
  - wr_addr and wr_data hold their last values when wr_en=0.
- Frame end: last pixel accepted in cycle N gives its wr_en in N+1 (state FLUSH), done in N+2, and in_ready back to 1 in no cycle before a new start.
- start while busy or in DONE is ignored.
- The address never exceeds DEPTH-1; there is no wrap within a frame. The next frame restarts at 0.
- Reset mid-frame:
  - Takes effect on the next edge. wr_en=0 from that cycle on; the pending write is dropped.
  - No done pulse is produced. State returns to IDLE.
- miss_count and miss_err persist after DONE until the next start or Reset.

Test Plan:
- DEPTH=8, start, then 8 back-to-back pixels 808,000,FCC,940,0AE,808,000,FCC -> wr_data 0,1,2,3,4,0,1,2 at addresses 0..7 on consecutive cycles, one cycle after each accept; done one cycle after the last wr_en; miss_count=0.
- DEPTH=8, in_valid toggled 1,0,0,1,... with palette colours -> wr_en only on the cycle after each accepted pixel; addresses contiguous 0..7; no write during gaps.
- Colours 123 and FFF mixed among palette colours (3 misses in 8 pixels) -> those writes carry wr_data=0; miss_count=3 and miss_err=1 after done; both clear on the next start.
- start asserted in RUN and in DONE -> no effect, counter unchanged. After done, a new start writes from address 0 again.
- Reset asserted after 4 of 8 pixels are accepted -> from the next edge wr_en=0, in_ready=0, busy=0, no done pulse; a subsequent start loads a full frame normally.
- Saturation with DEPTH=70000, ADDR_W=17, all pixels 0x555 -> miss_count stops at 16'hFFFF; the last write goes to address 69999.
